// File: rtl/line_refill_ctrl_if.sv
// Miss-request and backing-memory handshake bundle for line_refill_ctrl.
// master = refill engine side, slave = cache/memory side.
interface line_refill_ctrl_if;
  logic        miss_valid;
  logic [31:0] miss_addr;
  logic        miss_ready;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;

  modport master (
    input  miss_valid, miss_addr,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data,
    output miss_ready,
    output mem_req_valid, mem_req_addr
  );

  modport slave (
    output miss_valid, miss_addr,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data,
    input  miss_ready,
    input  mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/line_refill_ctrl.sv
// Cache line refill engine: one outstanding word read per beat.
// Define CRITICAL_WORD_FIRST_EN to start the refill at the missing word.
module line_refill_ctrl #(
  parameter int WORDS_PER_LINE = 16,
  parameter int INDEX_W        = 8,
  parameter int TAG_W          = 20,
  localparam int WW            = $clog2(WORDS_PER_LINE)
) (
  input  logic               clk,
  input  logic               rst_n,
  line_refill_ctrl_if.master bus,
  output logic               fill_we,
  output logic [INDEX_W-1:0] fill_index,
  output logic [WW-1:0]      fill_word,
  output logic [31:0]        fill_data,
  output logic               tag_we,
  output logic [TAG_W-1:0]   tag_out,
  output logic               refill_done,
  output logic [31:0]        refill_count,
  output logic               rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_e;

  localparam logic [WW-1:0] LAST = WW'(WORDS_PER_LINE - 1);

  state_e             state_q, state_d;
  logic [31-WW:0]     base_q, base_d;
  logic [WW-1:0]      word_q, word_d;
  logic [WW-1:0]      beat_q, beat_d;
  logic               fwe_q, fwe_d;
  logic [INDEX_W-1:0] fidx_q, fidx_d;
  logic [WW-1:0]      fword_q, fword_d;
  logic [31:0]        fdata_q, fdata_d;
  logic               twe_q, twe_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [31:0]        cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [WW-1:0]      start_w;

`ifdef CRITICAL_WORD_FIRST_EN
  assign start_w = bus.miss_addr[WW-1:0];
`else
  assign start_w = '0;
`endif

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    word_d  = word_q;
    beat_d  = beat_q;
    fwe_d   = 1'b0;
    fidx_d  = fidx_q;
    fword_d = fword_q;
    fdata_d = fdata_q;
    twe_d   = 1'b0;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    // Responses are only legal while a request is outstanding.
    err_d   = err_q
            | (bus.mem_rsp_valid && state_q != WAIT);
    unique case (state_q)
      IDLE: begin
        if (bus.miss_valid) begin
          base_d  = bus.miss_addr[31:WW];
          word_d  = start_w;
          beat_d  = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (bus.mem_rsp_valid) begin
          fwe_d   = 1'b1;
          fidx_d  = base_q[INDEX_W-1:0];
          fword_d = word_q;
          fdata_d = bus.mem_rsp_data;
          word_d  = word_q + WW'(1);
          beat_d  = beat_q + WW'(1);
          if (beat_q == LAST) begin
            twe_d   = 1'b1;
            tag_d   = base_q[31-WW -: TAG_W];
            state_d = DONE;
          end else begin
            state_d = REQ;
          end
        end
      end
      DONE: begin
        cnt_d   = cnt_q + 32'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      word_q  <= '0;
      beat_q  <= '0;
      fwe_q   <= 1'b0;
      fidx_q  <= '0;
      fword_q <= '0;
      fdata_q <= '0;
      twe_q   <= 1'b0;
      tag_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      word_q  <= word_d;
      beat_q  <= beat_d;
      fwe_q   <= fwe_d;
      fidx_q  <= fidx_d;
      fword_q <= fword_d;
      fdata_q <= fdata_d;
      twe_q   <= twe_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.miss_ready    = (state_q == IDLE);
  assign bus.mem_req_valid = (state_q == REQ);
  assign bus.mem_req_addr  = {base_q, word_q};
  assign refill_done       = (state_q == DONE);
  assign fill_we           = fwe_q;
  assign fill_index        = fidx_q;
  assign fill_word         = fword_q;
  assign fill_data         = fdata_q;
  assign tag_we            = twe_q;
  assign tag_out           = tag_q;
  assign refill_count      = cnt_q;
  assign rsp_err           = err_q;

endmodule

// File: tb/tb_line_refill_ctrl.sv
// Directed bench for line_refill_ctrl with a one-outstanding memory model.
// Honours CRITICAL_WORD_FIRST_EN for the expected word order.
module tb_line_refill_ctrl;

  logic        clk;
  logic        rst_n;
  logic        fill_we;
  logic [7:0]  fill_index;
  logic [3:0]  fill_word;
  logic [31:0] fill_data;
  logic        tag_we;
  logic [19:0] tag_out;
  logic        refill_done;
  logic [31:0] refill_count;
  logic        rsp_err;

  line_refill_ctrl_if mif ();

  line_refill_ctrl #(
    .WORDS_PER_LINE(16),
    .INDEX_W(8),
    .TAG_W(20)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (mif),
    .fill_we     (fill_we),
    .fill_index  (fill_index),
    .fill_word   (fill_word),
    .fill_data   (fill_data),
    .tag_we      (tag_we),
    .tag_out     (tag_out),
    .refill_done (refill_done),
    .refill_count(refill_count),
    .rsp_err     (rsp_err)
  );

  int          vec = 0;
  int          err = 0;
  int          cyc = 0;
  int          stall_n = 0;
  int          scnt = 0;
  logic        pend = 1'b0;
  logic        inj = 1'b0;
  logic [31:0] paddr = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One request outstanding: response appears the cycle after acceptance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
    end else if (mif.mem_req_valid && mif.mem_req_ready) begin
      pend  <= 1'b1;
      paddr <= mif.mem_req_addr;
    end else if (mif.mem_rsp_valid) begin
      pend <= 1'b0;
    end
  end

  always @(negedge clk) begin
    mif.mem_rsp_valid = pend | inj;
    mif.mem_rsp_data  = pend ? (paddr ^ 32'hA5A5_A5A5) : 32'hDEAD_BEEF;
    if (mif.mem_req_valid) begin
      mif.mem_req_ready = (scnt >= stall_n);
      scnt = scnt + 1;
    end else begin
      mif.mem_req_ready = 1'b0;
      scnt = 0;
    end
  end

  task automatic run_refill(input logic [31:0] addr, input int stall,
                            input int exp_cyc, input int abort_at);
    int          c0;
    int          k;
    bit          done;
    logic [3:0]  start;
    logic [3:0]  w;
    logic [31:0] exp_a;
`ifdef CRITICAL_WORD_FIRST_EN
    start = addr[3:0];
`else
    start = 4'd0;
`endif
    @(negedge clk);
    stall_n = stall;
    mif.miss_valid = 1'b1;
    mif.miss_addr  = addr;
    vec++;
    if (mif.miss_ready !== 1'b1) begin
      err++;
      $display("FAIL miss_ready_idle got=%b exp=1", mif.miss_ready);
    end
    @(posedge clk);
    #1 c0 = cyc;
    @(negedge clk);
    mif.miss_valid = 1'b0;
    mif.miss_addr  = ~addr;
    k = 0;
    done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      if (n > 0) @(negedge clk);
      if (fill_we) begin
        w = start + k[3:0];
        exp_a = {addr[31:4], w};
        vec++;
        if (fill_word !== w || fill_index !== addr[11:4] ||
            fill_data !== (exp_a ^ 32'hA5A5_A5A5)) begin
          err++;
          $display("FAIL fill_beat%0d got=%h/%h/%h exp=%h/%h/%h", k,
                   fill_index, fill_word, fill_data,
                   addr[11:4], w, exp_a ^ 32'hA5A5_A5A5);
        end
        vec++;
        if (tag_we !== (k == 15) ||
            (k == 15 && tag_out !== addr[31:12])) begin
          err++;
          $display("FAIL tag_we_beat%0d got=%b/%h exp=%b/%h", k,
                   tag_we, tag_out, (k == 15), addr[31:12]);
        end
        k++;
        if (k == abort_at) return;
      end
      if (mif.mem_req_valid) begin
        w = start + k[3:0];
        vec++;
        if (mif.mem_req_addr !== {addr[31:4], w}) begin
          err++;
          $display("FAIL req_addr got=%h exp=%h",
                   mif.mem_req_addr, {addr[31:4], w});
        end
      end
      if (refill_done) begin
        done = 1'b1;
        vec++;
        if (cyc - c0 + 1 !== exp_cyc || k !== 16) begin
          err++;
          $display("FAIL done_cycle got=%0d/%0d beats exp=%0d/16",
                   cyc - c0 + 1, k, exp_cyc);
        end
        vec++;
        if (mif.miss_ready !== 1'b0) begin
          err++;
          $display("FAIL miss_ready_done got=%b exp=0", mif.miss_ready);
        end
      end
    end
    if (!done) begin
      vec++;
      err++;
      $display("FAIL refill_timeout got=no_done exp=done");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if ({mif.miss_ready, mif.mem_req_valid, fill_we, tag_we,
         refill_done, rsp_err} !== 6'b100000) begin
      err++;
      $display("FAIL reset_flags got=%b exp=100000",
               {mif.miss_ready, mif.mem_req_valid, fill_we, tag_we,
                refill_done, rsp_err});
    end
    vec++;
    if ({refill_count, fill_index, fill_word, fill_data, tag_out}
        !== 96'd0) begin
      err++;
      $display("FAIL reset_regs got=%h/%h/%h/%h/%h exp=0",
               refill_count, fill_index, fill_word, fill_data, tag_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_refill(32'h0000_1234, 0, 33, 0);
    @(negedge clk);
    vec++;
    if (refill_count !== 32'd1 || mif.miss_ready !== 1'b1) begin
      err++;
      $display("FAIL basic_count got=%0d/%b exp=1/1",
               refill_count, mif.miss_ready);
    end
    vec++;
    if (rsp_err !== 1'b0) begin
      err++;
      $display("FAIL basic_no_err got=%b exp=0", rsp_err);
    end
  endtask

  task automatic test_rsp_err();
    @(posedge clk);
    #1 inj = 1'b1;
    @(posedge clk);
    #1 inj = 1'b0;
    @(negedge clk);
    vec++;
    if (rsp_err !== 1'b1 || fill_we !== 1'b0) begin
      err++;
      $display("FAIL stray_rsp got=%b/%b exp=1/0", rsp_err, fill_we);
    end
    run_refill(32'hFEDC_BA90, 0, 33, 0);
    @(negedge clk);
    vec++;
    if (rsp_err !== 1'b1 || refill_count !== 32'd2) begin
      err++;
      $display("FAIL err_sticky got=%b/%0d exp=1/2", rsp_err, refill_count);
    end
  endtask

  task automatic test_stall();
    run_refill(32'h1234_5678, 5, 113, 0);
    @(negedge clk);
    vec++;
    if (refill_count !== 32'd3) begin
      err++;
      $display("FAIL stall_count got=%0d exp=3", refill_count);
    end
  endtask

  task automatic test_abort();
    run_refill(32'h0000_1234, 0, 33, 8);
    #1 rst_n = 1'b0;
    #1;
    vec++;
    if ({mif.miss_ready, mif.mem_req_valid, fill_we, tag_we,
         refill_done, rsp_err} !== 6'b100000 ||
        {refill_count, fill_index, fill_word, fill_data, tag_out}
        !== 96'd0) begin
      err++;
      $display("FAIL abort_reset got=%b/%0d/%h exp=100000/0/0",
               {mif.miss_ready, mif.mem_req_valid, fill_we, tag_we,
                refill_done, rsp_err}, refill_count, tag_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      vec++;
      if (tag_we !== 1'b0 || mif.miss_ready !== 1'b1) begin
        err++;
        $display("FAIL abort_idle got=%b/%b exp=0/1",
                 tag_we, mif.miss_ready);
      end
    end
    run_refill(32'h0ABC_D5F0, 0, 33, 0);
    @(negedge clk);
    vec++;
    if (refill_count !== 32'd1) begin
      err++;
      $display("FAIL abort_recount got=%0d exp=1", refill_count);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mif.miss_valid    = 1'b0;
    mif.miss_addr     = '0;
    mif.mem_req_ready = 1'b0;
    mif.mem_rsp_valid = 1'b0;
    mif.mem_rsp_data  = '0;
    test_reset();
    test_basic();
    test_rsp_err();
    test_stall();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
